fir_tap_sequencer: RTL

- Time-multiplexes one shared sign-magnitude multiplier (comp_share_combined_top) across all taps of a direct-form FIR.
- Owns the sample delay line and the coefficient bank.
- For each accepted sample, issues one multiply per tap, accumulates the returned products and emits one filter output.
- Sits between the sample source and the shared multiplier instance.

---
 rtl/fir_seq_pkg.sv | 26 ++
 rtl/fir_coef_bank.sv | 49 ++++
 rtl/fir_tap_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_pkg.sv
// -----------------------------------------------------------------------------
// fir_seq_pkg
// Shared types and default widths for the time-multiplexed FIR tap sequencer.
//   state_t    : sequencer FSM states
//   DEF_*      : default sample / coefficient / product widths
//   acc_width(): accumulator width that cannot overflow for a given tap count
// -----------------------------------------------------------------------------
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_IN_DATA_WIDTH = 17;
  localparam int DEF_POLY_WIDTH    = 17;
  localparam int DEF_SUM_WIDTH     = 34;

  // Summing TAPS products of DEF_SUM_WIDTH bits needs log2(TAPS) guard bits.
  function automatic int acc_width(input int taps);
    return DEF_SUM_WIDTH + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
// TAPS x POLY_WIDTH coefficient register file.
//   clk, reset   : clock, asynchronous active-high reset (clears all entries)
//   idle_i       : writes are only honoured while the sequencer is idle
//   wr_en_i      : write strobe
//   wr_addr_i    : tap index to write
//   wr_data_i    : sign-magnitude coefficient
//   rd_addr_i    : tap index to read (combinational)
//   rd_data_o    : coefficient at rd_addr_i
// -----------------------------------------------------------------------------
module fir_coef_bank
  import fir_seq_pkg::*;
#(
  parameter int TAPS       = 8,
  parameter int POLY_WIDTH = DEF_POLY_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    idle_i,
  input  logic                    wr_en_i,
  input  logic [$clog2(TAPS)-1:0] wr_addr_i,
  input  logic [POLY_WIDTH-1:0]   wr_data_i,
  input  logic [$clog2(TAPS)-1:0] rd_addr_i,
  output logic [POLY_WIDTH-1:0]   rd_data_o
);

  logic [POLY_WIDTH-1:0] coef_q [TAPS];
  logic                  wr_ok;

  assign wr_ok = wr_en_i && idle_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (wr_ok) begin
      coef_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Write-through: a write landing in the same cycle as the read returns the
  // new value, so a coefficient written alongside a sample accept is the one
  // used for tap 0 of that sample.
  assign rd_data_o = (wr_ok && (wr_addr_i == rd_addr_i)) ? wr_data_i
                                                         : coef_q[rd_addr_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
// Direct-form FIR that time-shares one external sign-magnitude multiplier
// across all taps. Per accepted sample it issues one multiply per tap,
// accumulates the returned products and emits one filter output.
//   clk, reset          : clock, asynchronous active-high reset
//   in_data_vld/in_data : sample input, accepted when valid and in_data_rdy
//   in_data_rdy         : high only while idle
//   coef_wr_*           : coefficient write port (ignored unless idle)
//   mult_in_data_vld    : one-cycle issue pulse to the shared multiplier
//   mult_in_data        : operand sample x[k]
//   mult_polynomial     : operand coefficient coef[k]
//   mult_out_data(_vld) : product returned by the multiplier
//   out_data(_vld)      : filter output (two's complement) and its pulse
//   busy                : high whenever not idle
//   err                 : one-cycle pulse when a product never arrives
// -----------------------------------------------------------------------------
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAPS          = 8,
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int POLY_WIDTH    = DEF_POLY_WIDTH,
  parameter int SUM_WIDTH     = DEF_SUM_WIDTH,
  parameter int ACC_WIDTH     = acc_width(TAPS),
  parameter int WAIT_LIMIT    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_data_vld,
  input  logic [IN_DATA_WIDTH-1:0] in_data,
  output logic                     in_data_rdy,
  input  logic                     coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]  coef_wr_addr,
  input  logic [POLY_WIDTH-1:0]    coef_wr_data,
  output logic                     mult_in_data_vld,
  output logic [IN_DATA_WIDTH-1:0] mult_in_data,
  output logic [POLY_WIDTH-1:0]    mult_polynomial,
  input  logic [SUM_WIDTH-1:0]     mult_out_data,
  input  logic                     mult_out_data_vld,
  output logic [ACC_WIDTH-1:0]     out_data,
  output logic                     out_data_vld,
  output logic                     busy,
  output logic                     err
);

  localparam int K_W     = $clog2(TAPS);
  localparam int TIMER_W = $clog2(WAIT_LIMIT);

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic [SUM_WIDTH-1:0] p);
    logic signed [SUM_WIDTH-1:0] ps;
    ps = $signed(p);
    return ACC_WIDTH'(ps);
  endfunction

  state_t                       state_q, state_d;
  logic [K_W-1:0]               k_q, k_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [TIMER_W-1:0]           timer_q, timer_d;
  logic [IN_DATA_WIDTH-1:0]     x_q [TAPS];
  logic                         shift_en;
  logic                         abort;

  logic                         mult_vld_q;
  logic [IN_DATA_WIDTH-1:0]     mult_data_q, mult_data_d;
  logic [POLY_WIDTH-1:0]        mult_poly_q;
  logic [POLY_WIDTH-1:0]        coef_rd;
  logic signed [ACC_WIDTH-1:0]  out_data_q;
  logic                         out_vld_q;
  logic                         err_q;

  fir_coef_bank #(
    .TAPS       (TAPS),
    .POLY_WIDTH (POLY_WIDTH)
  ) u_coef_bank (
    .clk       (clk),
    .reset     (reset),
    .idle_i    (state_q == IDLE),
    .wr_en_i   (coef_wr_en),
    .wr_addr_i (coef_wr_addr),
    .wr_data_i (coef_wr_data),
    .rd_addr_i (k_d),
    .rd_data_o (coef_rd)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    timer_d  = timer_q;
    shift_en = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        // Products arriving here are strays and are deliberately dropped.
        if (in_data_vld) begin
          shift_en = 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mult_out_data_vld) begin
          acc_d = acc_q + sext_prod(mult_out_data);
          if (k_q == K_W'(TAPS - 1)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ISSUE;
          end
        end else if (timer_q == TIMER_W'(WAIT_LIMIT - 2)) begin
          // Timer counts WAIT cycles from 0; aborting here lands err exactly
          // WAIT_LIMIT cycles after the issue cycle.
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands are captured on entry to ISSUE so they are presented during the
  // ISSUE cycle itself; on accept the freshly shifted sample is x[0].
  assign mult_data_d = shift_en ? in_data : x_q[k_d];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      timer_q     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      mult_vld_q  <= 1'b0;
      mult_data_q <= '0;
      mult_poly_q <= '0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      if (shift_en) begin
        x_q[0] <= in_data;
        for (int i = 1; i < TAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      mult_vld_q <= (state_d == ISSUE);
      if (state_d == ISSUE) begin
        mult_data_q <= mult_data_d;
        mult_poly_q <= coef_rd;
      end
      // Output registers load with the final sum as the FSM enters DONE, so
      // out_data_vld is high during the DONE cycle.
      out_vld_q <= (state_d == DONE);
      if (state_d == DONE) begin
        out_data_q <= acc_d;
      end
      err_q <= abort;
    end
  end

  assign in_data_rdy      = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign mult_in_data_vld = mult_vld_q;
  assign mult_in_data     = mult_data_q;
  assign mult_polynomial  = mult_poly_q;
  assign out_data         = out_data_q;
  assign out_data_vld     = out_vld_q;
  assign err              = err_q;

endmodule
